// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a first-word-fall-through byte FIFO
module uart_rx_fifo #(
    parameter int FREQ_HZ    = 12562500,
    parameter int BAUDS      = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n_i,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       busy_o
);
    localparam int CLKS_PER_BIT = FREQ_HZ / BAUDS;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam int AW           = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    sh, sh_n;
    logic          rx_m, rx_s, push, ferr_n;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          full, pop, wr_en;

    assign pop     = valid_o && ready_i;
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign wr_en   = push && (!full || pop);
    assign valid_o = wr_ptr != rd_ptr;
    assign data_o  = mem[rd_ptr[AW-1:0]];

    // two-flop synchroniser for the asynchronous serial line, idling high
    always_ff @(posedge clk or negedge reset_n_i)
        if (!reset_n_i) {rx_m, rx_s} <= 2'b11;
        else {rx_m, rx_s} <= {rx_i, rx_m};

    // receiver state register; busy and frame error are registered with the state
    always_ff @(posedge clk or negedge reset_n_i)
        if (!reset_n_i) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            sh          <= '0;
            busy_o      <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            idx         <= idx_n;
            sh          <= sh_n;
            busy_o      <= state_n != IDLE;
            frame_err_o <= ferr_n;
        end

    // next-state: start is confirmed mid-bit, then every bit is sampled one bit period later
    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        idx_n   = idx;
        sh_n    = sh;
        push    = 1'b0;
        ferr_n  = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rx_s) state_n = START;
            end
            START: if (cnt == HALF_LAST) begin
                cnt_n   = '0;
                idx_n   = '0;
                state_n = rx_s ? IDLE : DATA;
            end
            DATA: if (cnt == BIT_LAST) begin
                cnt_n = '0;
                sh_n  = {rx_s, sh[7:1]};
                idx_n = idx + 3'd1;
                if (idx == 3'd7) state_n = STOP;
            end
            STOP: if (cnt == BIT_LAST) begin
                cnt_n   = '0;
                push    = rx_s;
                ferr_n  = !rx_s;
                state_n = rx_s ? IDLE : BRK;
            end
            BRK: begin
                cnt_n = '0;
                if (rx_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // FIFO storage and pointers; a push into a full FIFO only survives if a pop frees a slot
    always_ff @(posedge clk or negedge reset_n_i)
        if (!reset_n_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overrun_o <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr[AW-1:0]] <= sh;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            overrun_o <= push && full && !pop;
        end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed vectors and corner sequences for the UART receiver FIFO
module tb_uart_rx_fifo;
    logic       clk = 1'b0;
    logic       reset_n_i = 1'b0;
    logic       rx_i = 1'b1;
    logic       ready_i = 1'b0;
    logic [7:0] data_o;
    logic       valid_o, frame_err_o, overrun_o, busy_o;

    uart_rx_fifo #(.FREQ_HZ(16), .BAUDS(1), .FIFO_DEPTH(4)) dut (
        .clk(clk),
        .reset_n_i(reset_n_i),
        .rx_i(rx_i),
        .data_o(data_o),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .frame_err_o(frame_err_o),
        .overrun_o(overrun_o),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         ferr_cnt = 0, ovr_cnt = 0, ovr_cyc = 0, vhigh = 0, rise_cyc = 0, both_cnt = 0;
    logic       v_prev = 1'b0;
    logic [7:0] popped [$];

    always @(negedge clk) begin
        if (frame_err_o) ferr_cnt <= ferr_cnt + 1;
        if (overrun_o) begin
            ovr_cnt <= ovr_cnt + 1;
            ovr_cyc <= cyc;
        end
        if (frame_err_o && overrun_o) both_cnt <= both_cnt + 1;
        if (valid_o) vhigh <= vhigh + 1;
        if (valid_o && !v_prev) rise_cyc <= cyc;
        v_prev <= valid_o;
        if (valid_o && ready_i) popped.push_back(data_o);
    end

    int n_chk = 0, n_fail = 0;
    int frame_start = 0;
    int f0, o0, v0, p0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic snap();
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        v0 = vhigh;
        p0 = popped.size();
    endtask

    // 16 clocks per bit; stop sample lands 155 cycles after the start bit is driven
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic pop_at_stop);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 rx_i = bits[i];
            if (i == 0) frame_start = cyc;
            if (i == 9 && pop_at_stop) begin
                repeat (10) @(posedge clk);
                #1 ready_i = 1'b1;
                @(posedge clk);
                #1 ready_i = 1'b0;
                repeat (4) @(posedge clk);
            end else repeat (15) @(posedge clk);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_pops;
        logic [7:0] exp_byte;
        int         exp_ferr;
    } vec_t;

    vec_t tbl [5];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{8'hA5, 1'b1, 1, 8'hA5, 0};
        tbl[1] = '{8'h00, 1'b1, 1, 8'h00, 0};
        tbl[2] = '{8'hFF, 1'b1, 1, 8'hFF, 0};
        tbl[3] = '{8'h55, 1'b1, 1, 8'h55, 0};
        tbl[4] = '{8'hC3, 1'b0, 0, 8'h00, 1};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", valid_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_ferr", frame_err_o, 0);
        chk("rst_ovr", overrun_o, 0);
        reset_n_i = 1'b1;
        ready_i   = 1'b1;
        repeat (3) @(posedge clk);

        for (int k = 0; k < 5; k++) begin
            snap();
            send_frame(tbl[k].data, tbl[k].stop, 1'b0);
            if (!tbl[k].stop) begin
                repeat (8) @(posedge clk);
                #1 rx_i = 1'b1;
            end
            repeat (6) @(posedge clk);
            #1;
            chk("tbl_pops", popped.size() - p0, tbl[k].exp_pops);
            chk("tbl_ferr", ferr_cnt - f0, tbl[k].exp_ferr);
            chk("tbl_ovr", ovr_cnt - o0, 0);
            chk("tbl_busy", busy_o, 0);
            if (tbl[k].exp_pops > 0) begin
                chk("tbl_data", popped[p0], tbl[k].exp_byte);
                chk("tbl_latency", rise_cyc - frame_start, 155);
                chk("tbl_valid_cycles", vhigh - v0, 1);
            end
        end

        ready_i = 1'b0;
        snap();
        for (int k = 1; k <= 5; k++) send_frame(8'(k), 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("ovr_count", ovr_cnt - o0, 1);
        chk("ovr_timing", ovr_cyc - frame_start, 155);
        chk("ovr_no_pop", popped.size() - p0, 0);
        chk("ovr_valid", valid_o, 1);
        ready_i = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("ovr_drain_n", popped.size() - p0, 4);
        for (int k = 0; k < 4; k++) chk("ovr_drain", popped[p0 + k], k + 1);
        chk("ovr_empty", valid_o, 0);

        snap();
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (24) @(posedge clk);
        #1;
        chk("brk_busy", busy_o, 1);
        repeat (16) @(posedge clk);
        #1 rx_i = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("brk_idle", busy_o, 0);
        chk("brk_ferr", ferr_cnt - f0, 1);
        chk("brk_no_pop", popped.size() - p0, 0);
        chk("brk_valid", vhigh - v0, 0);
        send_frame(8'h55, 1'b1, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        chk("brk_next_n", popped.size() - p0, 1);
        chk("brk_next", popped[p0], 8'h55);

        snap();
        @(posedge clk);
        #1 rx_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("glitch_busy", busy_o, 1);
        rx_i = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("glitch_idle", busy_o, 0);
        chk("glitch_pops", popped.size() - p0, 0);
        chk("glitch_ferr", ferr_cnt - f0, 0);
        chk("glitch_ovr", ovr_cnt - o0, 0);

        ready_i = 1'b0;
        snap();
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        send_frame(8'h33, 1'b1, 1'b0);
        send_frame(8'h44, 1'b1, 1'b0);
        send_frame(8'h99, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("full_pop_ovr", ovr_cnt - o0, 0);
        chk("full_pop_one", popped.size() - p0, 1);
        ready_i = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("full_drain_n", popped.size() - p0, 5);
        chk("full_drain0", popped[p0], 8'h11);
        chk("full_drain1", popped[p0 + 1], 8'h22);
        chk("full_drain2", popped[p0 + 2], 8'h33);
        chk("full_drain3", popped[p0 + 3], 8'h44);
        chk("full_drain4", popped[p0 + 4], 8'h99);
        chk("full_empty", valid_o, 0);

        ready_i = 1'b0;
        send_frame(8'hC3, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_valid", valid_o, 1);
        chk("pre_rst_data", data_o, 8'hC3);
        for (int i = 0; i < 5; i++) begin
            logic [7:0] d;
            d = 8'h7E;
            @(posedge clk);
            #1 rx_i = (i == 0) ? 1'b0 : d[i-1];
            repeat (i == 4 ? 8 : 15) @(posedge clk);
        end
        #1;
        chk("mid_busy", busy_o, 1);
        #2 reset_n_i = 1'b0;
        #1;
        chk("arst_valid", valid_o, 0);
        chk("arst_data", data_o, 0);
        chk("arst_busy", busy_o, 0);
        chk("arst_ferr", frame_err_o, 0);
        chk("arst_ovr", overrun_o, 0);
        rx_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset_n_i = 1'b1;
        ready_i = 1'b1;
        snap();
        send_frame(8'h7E, 1'b1, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        chk("after_rst_n", popped.size() - p0, 1);
        chk("after_rst", popped[p0], 8'h7E);
        chk("never_both", both_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
